// File: rtl/ntt_stage_sequencer.sv
// Address/control sequencer for an in-place iterative NTT: issues one butterfly per cycle per stage.
// Optional Gentleman-Sande inverse ordering is compiled in with `define NTT_SEQ_INTT_EN.
module ntt_stage_sequencer #(
  parameter int LOGN = 10,
  parameter int PIPE = 8
) (
  input  logic            clk,
  input  logic            reset,
`ifdef NTT_SEQ_INTT_EN
  input  logic            inverse,
`endif
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [4:0]      stage,
  output logic            rd_valid,
  output logic [LOGN-1:0] rd_addr_top,
  output logic [LOGN-1:0] rd_addr_bot,
  output logic [LOGN-1:0] tw_addr,
  output logic            wr_valid,
  output logic [LOGN-1:0] wr_addr_top,
  output logic [LOGN-1:0] wr_addr_bot
);

  localparam logic [1:0]      IDLE   = 2'd0;
  localparam logic [1:0]      RUN    = 2'd1;
  localparam logic [1:0]      DRAIN  = 2'd2;
  localparam int              CW     = $clog2(PIPE + 2);
  localparam logic [LOGN-1:0] ONE    = LOGN'(1);
  localparam logic [LOGN-1:0] J_LAST = LOGN'((1 << (LOGN - 1)) - 1);
  localparam logic [4:0]      S_LAST = 5'(LOGN - 1);
  localparam logic [CW-1:0]   C_ONE  = CW'(1);
  localparam logic [CW-1:0]   C_DONE = CW'(PIPE);
  localparam logic [CW-1:0]   C_LAST = CW'(PIPE + 1);

  logic [1:0]      state_r;
  logic [LOGN-1:0] j_r;
  logic [4:0]      stage_r;
  logic [CW-1:0]   cnt_r;
  logic [2*LOGN:0] dl_r [PIPE];

  logic            iss_s;
  logic            iss_inv_s;
  logic [4:0]      iss_stage_s;
  logic [LOGN-1:0] iss_j_s;
  logic [4:0]      lh_s;
  logic [4:0]      tws_s;
  logic [LOGN-1:0] h_s, g_s, k_s, top_s, bot_s, tw_s;

`ifdef NTT_SEQ_INTT_EN
  logic inv_r;
  // The direction seen at start drives the first butterfly; later ones use the latched copy.
  assign iss_inv_s = (state_r == IDLE) ? inverse : inv_r;

  // Latch the transform direction when a start is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      inv_r <= 1'b0;
    end else if (state_r == IDLE && start) begin
      inv_r <= inverse;
    end else begin
      inv_r <= inv_r;
    end
  end
`else
  assign iss_inv_s = 1'b0;
`endif

  // Decide whether a butterfly is issued this cycle and for which stage/index.
  always_comb begin
    iss_s       = 1'b0;
    iss_stage_s = stage_r;
    iss_j_s     = j_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          iss_s       = 1'b1;
          iss_stage_s = 5'd0;
          iss_j_s     = {LOGN{1'b0}};
        end else begin
          iss_s = 1'b0;
        end
      end
      RUN: iss_s = 1'b1;
      DRAIN: begin
        // Last drain cycle of a non-final stage issues the next stage's first butterfly.
        if (cnt_r == C_LAST && stage_r != S_LAST) begin
          iss_s       = 1'b1;
          iss_stage_s = stage_r + 5'd1;
          iss_j_s     = {LOGN{1'b0}};
        end else begin
          iss_s = 1'b0;
        end
      end
      default: iss_s = 1'b0;
    endcase
  end

  // Butterfly addresses; forward and inverse orderings swap the span and twiddle-base exponents.
  always_comb begin
    if (iss_inv_s) begin
      lh_s  = iss_stage_s;
      tws_s = S_LAST - iss_stage_s;
    end else begin
      lh_s  = S_LAST - iss_stage_s;
      tws_s = iss_stage_s;
    end
    h_s   = ONE << lh_s;
    g_s   = iss_j_s >> lh_s;
    k_s   = iss_j_s & (h_s - ONE);
    top_s = (g_s << (lh_s + 5'd1)) | k_s;
    bot_s = top_s + h_s;
    tw_s  = (ONE << tws_s) + g_s;
  end

  // Stage FSM, butterfly/drain counters and registered issue-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      j_r         <= {LOGN{1'b0}};
      stage_r     <= 5'd0;
      cnt_r       <= {CW{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      stage       <= 5'd0;
      rd_valid    <= 1'b0;
      rd_addr_top <= {LOGN{1'b0}};
      rd_addr_bot <= {LOGN{1'b0}};
      tw_addr     <= {LOGN{1'b0}};
    end else begin
      rd_valid <= iss_s;
      done     <= 1'b0;
      if (iss_s) begin
        rd_addr_top <= top_s;
        rd_addr_bot <= bot_s;
        tw_addr     <= tw_s;
        stage       <= iss_stage_s;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= RUN;
            busy    <= 1'b1;
            j_r     <= ONE;
            stage_r <= 5'd0;
          end
        end
        RUN: begin
          if (j_r == J_LAST) begin
            state_r <= DRAIN;
            cnt_r   <= {CW{1'b0}};
          end else begin
            j_r <= j_r + ONE;
          end
        end
        DRAIN: begin
          cnt_r <= cnt_r + C_ONE;
          if (cnt_r == C_DONE && stage_r == S_LAST) begin
            done  <= 1'b1;
            stage <= 5'd0;
          end
          if (cnt_r == C_LAST) begin
            if (stage_r == S_LAST) begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end else begin
              state_r <= RUN;
              stage_r <= stage_r + 5'd1;
              j_r     <= ONE;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Write-back delay line: PIPE registers carrying {valid, top, bot}.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE; i++) dl_r[i] <= {(2*LOGN+1){1'b0}};
    end else begin
      dl_r[0] <= {rd_valid, rd_addr_top, rd_addr_bot};
      for (int i = 1; i < PIPE; i++) dl_r[i] <= dl_r[i-1];
    end
  end

  assign {wr_valid, wr_addr_top, wr_addr_bot} = dl_r[PIPE-1];

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Scoreboard bench for ntt_stage_sequencer: small LOGN=3/PIPE=2 instance with directed vectors,
// plus a LOGN=10/PIPE=8 instance checked for latency, run length and address coverage.
module tb_ntt_stage_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // small instance
  logic       reset, start, busy, done, rd_valid, wr_valid;
  logic [4:0] stage;
  logic [2:0] rd_addr_top, rd_addr_bot, tw_addr, wr_addr_top, wr_addr_bot;
  // large instance
  logic       reset_b, start_b, busy_b, done_b, rd_valid_b, wr_valid_b;
  logic [4:0] stage_b;
  logic [9:0] rd_addr_top_b, rd_addr_bot_b, tw_addr_b, wr_addr_top_b, wr_addr_bot_b;
`ifdef NTT_SEQ_INTT_EN
  logic inverse, inverse_b;
`endif

  ntt_stage_sequencer #(.LOGN(3), .PIPE(2)) dut (
    .clk(clk), .reset(reset),
`ifdef NTT_SEQ_INTT_EN
    .inverse(inverse),
`endif
    .start(start), .busy(busy), .done(done), .stage(stage),
    .rd_valid(rd_valid), .rd_addr_top(rd_addr_top), .rd_addr_bot(rd_addr_bot), .tw_addr(tw_addr),
    .wr_valid(wr_valid), .wr_addr_top(wr_addr_top), .wr_addr_bot(wr_addr_bot)
  );

  ntt_stage_sequencer #(.LOGN(10), .PIPE(8)) dut_b (
    .clk(clk), .reset(reset_b),
`ifdef NTT_SEQ_INTT_EN
    .inverse(inverse_b),
`endif
    .start(start_b), .busy(busy_b), .done(done_b), .stage(stage_b),
    .rd_valid(rd_valid_b), .rd_addr_top(rd_addr_top_b), .rd_addr_bot(rd_addr_bot_b), .tw_addr(tw_addr_b),
    .wr_valid(wr_valid_b), .wr_addr_top(wr_addr_top_b), .wr_addr_bot(wr_addr_bot_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Hand-computed read tables for N=8 (offsets relative to the start cycle)
  int offs  [12] = '{1, 2, 3, 4, 8, 9, 10, 11, 15, 16, 17, 18};
  int fw_top[12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
  int fw_bot[12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
  int fw_tw [12] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7};
  int iv_top[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int iv_bot[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int iv_tw [12] = '{4, 5, 6, 7, 2, 2, 3, 3, 1, 1, 1, 1};

  typedef struct {int cyc; int top; int bot; int tw; int stg;} rd_t;
  typedef struct {int cyc; int top; int bot;} wr_t;
  typedef struct {int cyc; int sig; int val;} pt_t;

  rd_t exp_rd[$];
  wr_t exp_wr[$];
  int  exp_done[$];
  pt_t exp_pt[$];
  string sig_name[7] = '{"busy", "stage", "rd_valid", "wr_valid", "done", "tw_addr", "wr_addr_top"};

  task automatic push_transform(input int t0, input int inv, input int nrd, input int nwr);
    rd_t r;
    wr_t w;
    for (int i = 0; i < nrd; i++) begin
      r.cyc = t0 + offs[i];
      r.top = inv ? iv_top[i] : fw_top[i];
      r.bot = inv ? iv_bot[i] : fw_bot[i];
      r.tw  = inv ? iv_tw[i]  : fw_tw[i];
      r.stg = i / 4;
      exp_rd.push_back(r);
    end
    for (int i = 0; i < nwr; i++) begin
      w.cyc = t0 + offs[i] + 2;
      w.top = inv ? iv_top[i] : fw_top[i];
      w.bot = inv ? iv_bot[i] : fw_bot[i];
      exp_wr.push_back(w);
    end
  endtask

  task automatic push_pt(input int c, input int sig, input int val);
    pt_t p;
    p.cyc = c; p.sig = sig; p.val = val;
    exp_pt.push_back(p);
  endtask

  function automatic int sig_val(input int sig);
    case (sig)
      0: return int'(busy);
      1: return int'(stage);
      2: return int'(rd_valid);
      3: return int'(wr_valid);
      4: return int'(done);
      5: return int'(tw_addr);
      6: return int'(wr_addr_top);
      default: return -1;
    endcase
  endfunction

  int last_wr_cyc = -100;
  int last_rd_stg = -1;

  // Scoreboard monitor for the small instance
  always @(negedge clk) begin
    rd_t r;
    wr_t w;
    pt_t p;
    int  d;
    while (exp_pt.size() > 0 && exp_pt[0].cyc <= cyc) begin
      p = exp_pt.pop_front();
      check($sformatf("%s@%0d", sig_name[p.sig], p.cyc), sig_val(p.sig), p.val);
    end
    if (wr_valid) begin
      if (exp_wr.size() == 0) check("wr_unexpected", cyc, -1);
      else begin
        w = exp_wr.pop_front();
        check("wr_cycle", cyc, w.cyc);
        check("wr_top", int'(wr_addr_top), w.top);
        check("wr_bot", int'(wr_addr_bot), w.bot);
      end
      last_wr_cyc = cyc;
    end else if (exp_wr.size() > 0 && exp_wr[0].cyc <= cyc) begin
      w = exp_wr.pop_front();
      check("wr_missing", -1, w.cyc);
    end
    if (rd_valid) begin
      if (exp_rd.size() == 0) check("rd_unexpected", cyc, -1);
      else begin
        r = exp_rd.pop_front();
        check("rd_cycle", cyc, r.cyc);
        check("rd_top", int'(rd_addr_top), r.top);
        check("rd_bot", int'(rd_addr_bot), r.bot);
        check("rd_tw", int'(tw_addr), r.tw);
        check("rd_stage", int'(stage), r.stg);
      end
      if (last_rd_stg >= 0 && int'(stage) == last_rd_stg + 1)
        check("stage_gap_after_last_wr", int'(cyc - last_wr_cyc >= 2), 1);
      last_rd_stg = int'(stage);
    end else if (exp_rd.size() > 0 && exp_rd[0].cyc <= cyc) begin
      r = exp_rd.pop_front();
      check("rd_missing", -1, r.cyc);
    end
    if (done) begin
      if (exp_done.size() == 0) check("done_unexpected", cyc, -1);
      else begin
        d = exp_done.pop_front();
        check("done_cycle", cyc, d);
      end
    end else if (exp_done.size() > 0 && exp_done[0] <= cyc) begin
      d = exp_done.pop_front();
      check("done_missing", -1, d);
    end
  end

  logic [1023:0] seen_b;
  int  run_len_b = 0, dup_b = 0, nruns_b = 0, ndone_b = 0, t0_b = 0;
  bit  in_run_b = 1'b0;

  // Monitor for the large instance: contiguous runs, coverage and done latency
  always @(negedge clk) begin
    if (rd_valid_b) begin
      if (!in_run_b) begin
        in_run_b  = 1'b1;
        run_len_b = 0;
        dup_b     = 0;
        seen_b    = '0;
        check("b_stage", int'(stage_b), nruns_b);
      end
      run_len_b++;
      if (seen_b[rd_addr_top_b]) dup_b++;
      seen_b[rd_addr_top_b] = 1'b1;
      if (seen_b[rd_addr_bot_b]) dup_b++;
      seen_b[rd_addr_bot_b] = 1'b1;
    end else if (in_run_b) begin
      in_run_b = 1'b0;
      check("b_run_len", run_len_b, 512);
      check("b_coverage", $countones(seen_b), 1024);
      check("b_duplicates", dup_b, 0);
      nruns_b++;
    end
    if (done_b) begin
      ndone_b++;
      check("b_done_latency", cyc - t0_b, 5210);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int t0, t1;

  initial begin
    reset = 1'b1; reset_b = 1'b1; start = 1'b0; start_b = 1'b0;
`ifdef NTT_SEQ_INTT_EN
    inverse = 1'b0; inverse_b = 1'b0;
`endif
    tick(); tick();
    for (int s = 0; s < 7; s++) push_pt(cyc, s, 0);
    reset = 1'b0; reset_b = 1'b0;
    tick();

    // Forward transform, ignored starts at 5 and 21, restart at 22
    t0 = cyc; t0_b = cyc;
    start = 1'b1; start_b = 1'b1;
    push_transform(t0, 0, 12, 12);
    push_transform(t0 + 22, 0, 12, 12);
    exp_done.push_back(t0 + 21);
    exp_done.push_back(t0 + 43);
    push_pt(t0 + 1, 0, 1);
    push_pt(t0 + 7, 1, 0);
    push_pt(t0 + 8, 1, 1);
    push_pt(t0 + 21, 0, 1);
    push_pt(t0 + 21, 1, 0);
    push_pt(t0 + 22, 0, 0);
    push_pt(t0 + 23, 0, 1);
    for (int c = 1; c <= 50; c++) begin
      tick();
      start   = (c == 5 || c == 21 || c == 22);
      start_b = 1'b0;
    end
    tick();
    start = 1'b0;

    // Reset during stage 1 aborts the transform
    tick();
    t1 = cyc;
    start = 1'b1;
    push_transform(t1, 0, 6, 4);
    push_pt(t1 + 10, 0, 0);
    push_pt(t1 + 10, 1, 0);
    push_pt(t1 + 10, 2, 0);
    push_pt(t1 + 10, 3, 0);
    for (int c = 1; c <= 40; c++) begin
      tick();
      start = 1'b0;
      reset = (c == 9);
    end

`ifdef NTT_SEQ_INTT_EN
    // Inverse (Gentleman-Sande) ordering
    tick();
    t1 = cyc;
    start = 1'b1; inverse = 1'b1;
    push_transform(t1, 1, 12, 12);
    exp_done.push_back(t1 + 21);
    for (int c = 1; c <= 30; c++) begin
      tick();
      start = 1'b0; inverse = 1'b0;
    end
`endif

    while (cyc < t0 + 5230) tick();

    check("rd_queue_drained", exp_rd.size(), 0);
    check("wr_queue_drained", exp_wr.size(), 0);
    check("done_queue_drained", exp_done.size(), 0);
    check("pt_queue_drained", exp_pt.size(), 0);
    check("b_stage_runs", nruns_b, 10);
    check("b_done_count", ndone_b, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
